sopc_run_ctrl: RTL and testbench

//  Run controller for the minimal SoPC: sequences core reset release, counts run cycles, detects end of test.

---
 rtl/sopc_run_ctrl_pkg.sv | 44 ++++
 rtl/sopc_run_ctrl_pc_stall_det.sv | 56 +++++
 rtl/sopc_run_ctrl.sv | 129 ++++++++++++
 tb/tb_sopc_run_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sopc_run_ctrl_pkg.sv
// Shared definitions for the SoPC run controller: run-state encodings,
// verdict codes and the state-to-verdict mapping.
package sopc_run_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned STATUS_W = 3;

    // Run-controller states
    typedef enum logic [STATE_W-1:0] {
        RUN_HOLD    = 3'd0,
        RUN_RUN     = 3'd1,
        RUN_PASS    = 3'd2,
        RUN_FAIL    = 3'd3,
        RUN_HANG    = 3'd4,
        RUN_TIMEOUT = 3'd5
    } run_state_e;

    // Verdict codes reported on status_o
    localparam logic [STATUS_W-1:0] ST_NONE    = 3'd0;
    localparam logic [STATUS_W-1:0] ST_PASS    = 3'd1;
    localparam logic [STATUS_W-1:0] ST_FAIL    = 3'd2;
    localparam logic [STATUS_W-1:0] ST_HANG    = 3'd3;
    localparam logic [STATUS_W-1:0] ST_TIMEOUT = 3'd4;

    // Verdict code carried by a state (ST_NONE while not terminal)
    function automatic logic [STATUS_W-1:0] status_of(input run_state_e s);
        logic [STATUS_W-1:0] st;
        st = ST_NONE;
        case (s)
            RUN_PASS:    st = ST_PASS;
            RUN_FAIL:    st = ST_FAIL;
            RUN_HANG:    st = ST_HANG;
            RUN_TIMEOUT: st = ST_TIMEOUT;
            default:     st = ST_NONE;
        endcase
        return st;
    endfunction

    // True for the sticky verdict states
    function automatic logic is_terminal(input run_state_e s);
        return (s != RUN_HOLD) && (s != RUN_RUN);
    endfunction

endpackage

// File: rtl/sopc_run_ctrl_pc_stall_det.sv
// PC stall detector: tracks the last fetch PC and counts consecutive run
// cycles on which it has not changed.
//  clk, rst     clock, synchronous active-high reset
//  run_en       high while the controller is in RUN; low clears the detector
//  pc_i         core fetch PC
//  stall_hit_c  combinational: this cycle brings the stall count to STALL_LIMIT
module sopc_run_ctrl_pc_stall_det #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              stall_hit_c
);

    localparam int unsigned STALL_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);

    logic [ADDR_W-1:0]  pc_q;
    logic               pc_valid_q;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_cnt_nxt;
    logic               same_pc;

    assign same_pc = (pc_i == pc_q);

    // First run cycle only loads pc_q; afterwards count unchanged PCs, saturating
    always_comb begin
        stall_cnt_nxt = '0;
        if (pc_valid_q && same_pc) begin
            if (stall_cnt == STALL_W'(STALL_LIMIT)) begin
                stall_cnt_nxt = stall_cnt;
            end else begin
                stall_cnt_nxt = stall_cnt + STALL_W'(1);
            end
        end
    end

    // A limit of zero disables hang detection
    assign stall_hit_c = (STALL_LIMIT != 0) && run_en && pc_valid_q && same_pc &&
                         (stall_cnt_nxt == STALL_W'(STALL_LIMIT));

    always_ff @(posedge clk) begin
        if (rst || !run_en) begin
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            pc_q       <= pc_i;
            pc_valid_q <= 1'b1;
            stall_cnt  <= stall_cnt_nxt;
        end
    end

endmodule

// File: rtl/sopc_run_ctrl.sv
// Run controller for the minimal SoPC: holds the core in reset for
// RST_CYCLES after rst falls, counts run cycles, and latches a sticky
// PASS / FAIL / HANG / TIMEOUT verdict.
//  clk, rst     clock, synchronous active-high reset
//  core_rst_o   reset to the core, active-high
//  pc_i         core fetch PC
//  mem_we_i     data-bus write strobe, mem_addr_i / mem_data_i its payload
//  cycle_cnt_o  run cycles elapsed (frozen once a verdict is reached)
//  done_o       verdict reached (sticky)
//  status_o     verdict code
//  result_o     data of the terminating store
module sopc_run_ctrl
    import sopc_run_ctrl_pkg::*;
#(
    parameter int unsigned       RST_CYCLES  = 10,
    parameter int unsigned       CNT_W       = 32,
    parameter int unsigned       MAX_CYCLES  = 50,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR   = ADDR_W'(32'h0000_1000),
    parameter int unsigned       STALL_LIMIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic                core_rst_o,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic                done_o,
    output logic [STATUS_W-1:0] status_o,
    output logic [DATA_W-1:0]   result_o
);

    localparam int unsigned HOLD_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

    run_state_e         state;
    run_state_e         state_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_cnt_nxt;
    logic [CNT_W-1:0]   cycle_cnt_nxt;
    logic [DATA_W-1:0]  result_nxt;
    logic               core_rst_nxt;
    logic               done_nxt;
    logic [STATUS_W-1:0] status_nxt;
    logic               stall_hit_c;
    logic               halt_store_c;

    sopc_run_ctrl_pc_stall_det #(
        .ADDR_W      (ADDR_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_pc_stall_det (
        .clk         (clk),
        .rst         (rst),
        .run_en      (state == RUN_RUN),
        .pc_i        (pc_i),
        .stall_hit_c (stall_hit_c)
    );

    assign halt_store_c = mem_we_i && (mem_addr_i == HALT_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next register values; halt store > hang > timeout
    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        cycle_cnt_nxt = cycle_cnt_o;
        result_nxt    = result_o;

        case (state)
            RUN_HOLD: begin
                if (hold_cnt == HOLD_W'(RST_CYCLES)) begin
                    state_nxt = RUN_RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            RUN_RUN: begin
                if (cycle_cnt_o != '1) begin
                    cycle_cnt_nxt = cycle_cnt_o + CNT_W'(1);
                end
                if (halt_store_c) begin
                    result_nxt = mem_data_i;
                    state_nxt  = (mem_data_i == DATA_W'(1)) ? RUN_PASS : RUN_FAIL;
                end else if (stall_hit_c) begin
                    state_nxt = RUN_HANG;
                end else if (cycle_cnt_o == CNT_W'(MAX_CYCLES - 1)) begin
                    state_nxt = RUN_TIMEOUT;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase

        core_rst_nxt = (state_nxt == RUN_HOLD);
        done_nxt     = is_terminal(state_nxt);
        status_nxt   = status_of(state_nxt);
    end

    // Counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt    <= '0;
            cycle_cnt_o <= '0;
            result_o    <= '0;
            core_rst_o  <= 1'b1;
            done_o      <= 1'b0;
            status_o    <= ST_NONE;
        end else begin
            hold_cnt    <= hold_cnt_nxt;
            cycle_cnt_o <= cycle_cnt_nxt;
            result_o    <= result_nxt;
            core_rst_o  <= core_rst_nxt;
            done_o      <= done_nxt;
            status_o    <= status_nxt;
        end
    end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl with default parameters.
module tb_sopc_run_ctrl;

    logic        clk;
    logic        rst;
    logic        core_rst_o;
    logic [31:0] pc_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] cycle_cnt_o;
    logic        done_o;
    logic [2:0]  status_o;
    logic [31:0] result_o;

    int n_vec;
    int n_err;

    sopc_run_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .core_rst_o  (core_rst_o),
        .pc_i        (pc_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .cycle_cnt_o (cycle_cnt_o),
        .done_o      (done_o),
        .status_o    (status_o),
        .result_o    (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for 5 cycles, release, and count edges until the core is released
    task automatic start_run(output int edges);
        rst        = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = '0;
        mem_data_i = '0;
        repeat (5) tick();
        rst   = 1'b0;
        edges = 0;
        while (core_rst_o === 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    // n run cycles, PC changes every cycle
    task automatic run_toggle(input int n);
        for (int i = 0; i < n; i++) begin
            pc_i = pc_i + 32'd4;
            tick();
        end
    endtask

    // One cycle with a data-bus store, PC advancing
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mem_we_i   = 1'b1;
        mem_addr_i = addr;
        mem_data_i = data;
        pc_i       = pc_i + 32'd4;
        tick();
        mem_we_i   = 1'b0;
        mem_addr_i = '0;
        mem_data_i = '0;
    endtask

    task automatic test_reset();
        int edges;
        rst = 1'b1;
        repeat (3) tick();
        n_vec++; if (core_rst_o !== 1'b1) begin n_err++; $display("FAIL reset_core_rst: got %0b want 1", core_rst_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done_o); end
        n_vec++; if (status_o !== 3'd0) begin n_err++; $display("FAIL reset_status: got %0d want 0", status_o); end
        n_vec++; if (cycle_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cycle_cnt_o); end
        n_vec++; if (result_o !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result_o); end
        start_run(edges);
        n_vec++; if (edges != 11) begin n_err++; $display("FAIL release_latency: got %0d edges want 11", edges); end
        n_vec++; if (cycle_cnt_o !== 32'd0) begin n_err++; $display("FAIL run_start_cnt: got %0d want 0", cycle_cnt_o); end
        run_toggle(3);
        n_vec++; if (cycle_cnt_o !== 32'd3) begin n_err++; $display("FAIL run_cnt3: got %0d want 3", cycle_cnt_o); end
        n_vec++; if (core_rst_o !== 1'b0) begin n_err++; $display("FAIL run_core_rst: got %0b want 0", core_rst_o); end
    endtask

    task automatic test_pass();
        int edges;
        start_run(edges);
        run_toggle(20);
        store(32'h1000, 32'h1);
        n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL pass_done: got %0b want 1", done_o); end
        n_vec++; if (status_o !== 3'd1) begin n_err++; $display("FAIL pass_status: got %0d want 1", status_o); end
        n_vec++; if (result_o !== 32'h1) begin n_err++; $display("FAIL pass_result: got %h want 1", result_o); end
        n_vec++; if (cycle_cnt_o !== 32'd21) begin n_err++; $display("FAIL pass_cnt: got %0d want 21", cycle_cnt_o); end
        store(32'h1000, 32'h7);
        run_toggle(3);
        n_vec++; if (status_o !== 3'd1) begin n_err++; $display("FAIL pass_sticky_status: got %0d want 1", status_o); end
        n_vec++; if (result_o !== 32'h1) begin n_err++; $display("FAIL pass_sticky_result: got %h want 1", result_o); end
        n_vec++; if (cycle_cnt_o !== 32'd21) begin n_err++; $display("FAIL pass_frozen_cnt: got %0d want 21", cycle_cnt_o); end
        n_vec++; if (core_rst_o !== 1'b0) begin n_err++; $display("FAIL pass_core_rst: got %0b want 0", core_rst_o); end
    endtask

    task automatic test_fail();
        int edges;
        start_run(edges);
        run_toggle(5);
        store(32'h1004, 32'h1);
        store(32'h8000_1000, 32'h1);
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL other_addr_ignored: got done %0b want 0", done_o); end
        run_toggle(3);
        store(32'h1000, 32'h7);
        n_vec++; if (status_o !== 3'd2) begin n_err++; $display("FAIL fail_status: got %0d want 2", status_o); end
        n_vec++; if (result_o !== 32'h7) begin n_err++; $display("FAIL fail_result: got %h want 7", result_o); end
        n_vec++; if (cycle_cnt_o !== 32'd11) begin n_err++; $display("FAIL fail_cnt: got %0d want 11", cycle_cnt_o); end
        n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL fail_done: got %0b want 1", done_o); end
    endtask

    task automatic test_hang();
        int edges;
        start_run(edges);
        pc_i = 32'h80;
        repeat (16) tick();
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL hang_early: got done %0b want 0", done_o); end
        tick();
        n_vec++; if (status_o !== 3'd3) begin n_err++; $display("FAIL hang_status: got %0d want 3", status_o); end
        n_vec++; if (cycle_cnt_o !== 32'd17) begin n_err++; $display("FAIL hang_cnt: got %0d want 17", cycle_cnt_o); end
        n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL hang_done: got %0b want 1", done_o); end
    endtask

    task automatic test_timeout();
        int edges;
        start_run(edges);
        pc_i = 32'h200;
        // 15 unchanged-PC cycles after the loading cycle: one short of a hang
        repeat (16) tick();
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL stall15_no_hang: got done %0b want 0", done_o); end
        run_toggle(33);
        n_vec++; if (done_o !== 1'b0 || cycle_cnt_o !== 32'd49) begin n_err++; $display("FAIL pre_timeout: got done %0b cnt %0d want 0 49", done_o, cycle_cnt_o); end
        run_toggle(1);
        n_vec++; if (status_o !== 3'd4) begin n_err++; $display("FAIL timeout_status: got %0d want 4", status_o); end
        n_vec++; if (cycle_cnt_o !== 32'd50) begin n_err++; $display("FAIL timeout_cnt: got %0d want 50", cycle_cnt_o); end
        run_toggle(3);
        n_vec++; if (cycle_cnt_o !== 32'd50 || status_o !== 3'd4) begin n_err++; $display("FAIL timeout_frozen: got cnt %0d status %0d want 50 4", cycle_cnt_o, status_o); end
    endtask

    task automatic test_halt_on_timeout();
        int edges;
        start_run(edges);
        run_toggle(49);
        store(32'h1000, 32'h1);
        n_vec++; if (status_o !== 3'd1) begin n_err++; $display("FAIL halt_beats_timeout: got %0d want 1", status_o); end
        n_vec++; if (cycle_cnt_o !== 32'd50) begin n_err++; $display("FAIL halt_timeout_cnt: got %0d want 50", cycle_cnt_o); end
    endtask

    task automatic test_hang_vs_timeout();
        int edges;
        start_run(edges);
        run_toggle(34);
        // PC frozen from cycle 34: the 16th unchanged cycle is cycle 49
        repeat (15) tick();
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL hang_tmo_early: got done %0b want 0", done_o); end
        tick();
        n_vec++; if (status_o !== 3'd3) begin n_err++; $display("FAIL hang_beats_timeout: got %0d want 3", status_o); end
        n_vec++; if (cycle_cnt_o !== 32'd50) begin n_err++; $display("FAIL hang_tmo_cnt: got %0d want 50", cycle_cnt_o); end
    endtask

    task automatic test_mid_reset();
        int edges;
        start_run(edges);
        run_toggle(7);
        n_vec++; if (cycle_cnt_o !== 32'd7) begin n_err++; $display("FAIL mid_cnt: got %0d want 7", cycle_cnt_o); end
        rst = 1'b1;
        tick();
        n_vec++; if (core_rst_o !== 1'b1 || done_o !== 1'b0 || cycle_cnt_o !== 32'd0) begin n_err++; $display("FAIL mid_run_reset: got core_rst %0b done %0b cnt %0d want 1 0 0", core_rst_o, done_o, cycle_cnt_o); end
        start_run(edges);
        n_vec++; if (edges != 11) begin n_err++; $display("FAIL replay_latency: got %0d edges want 11", edges); end
        run_toggle(2);
        store(32'h1000, 32'h1);
        n_vec++; if (status_o !== 3'd1 || cycle_cnt_o !== 32'd3) begin n_err++; $display("FAIL replay_pass: got status %0d cnt %0d want 1 3", status_o, cycle_cnt_o); end
        rst = 1'b1;
        tick();
        n_vec++; if (core_rst_o !== 1'b1 || done_o !== 1'b0 || cycle_cnt_o !== 32'd0) begin n_err++; $display("FAIL post_pass_reset: got core_rst %0b done %0b cnt %0d want 1 0 0", core_rst_o, done_o, cycle_cnt_o); end
        n_vec++; if (status_o !== 3'd0 || result_o !== 32'd0) begin n_err++; $display("FAIL post_pass_clear: got status %0d result %h want 0 0", status_o, result_o); end
        rst = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        pc_i       = 32'h0;
        mem_we_i   = 1'b0;
        mem_addr_i = '0;
        mem_data_i = '0;
        test_reset();
        test_pass();
        test_fail();
        test_hang();
        test_timeout();
        test_halt_on_timeout();
        test_hang_vs_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
